// File: rtl/byte_lane_arbiter_pkg.sv
// Shared width codes, lane state record and width helpers for the byte lane arbiter.
package byte_lane_arbiter_pkg;

  localparam logic [1:0] W8    = 2'b00;
  localparam logic [1:0] W16   = 2'b01;
  localparam logic [1:0] W32   = 2'b10;
  localparam logic [1:0] W8ALT = 2'b11;

  typedef struct packed {
    logic        busy;
    logic        first;
    logic [1:0]  cnt;    // bytes remaining after the presented one
    logic [1:0]  code;
    logic [31:0] sh;
  } lane_t;

  function automatic logic [2:0] bytes_of(input logic [1:0] code);
    case (code)
      W16:     return 3'd2;
      W32:     return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  // Left-justify the right-aligned word so the first byte sits in [31:24].
  function automatic logic [31:0] align_msb(input logic [1:0] code, input logic [31:0] word);
    case (code)
      W16:     return {word[15:0], 16'h0000};
      W32:     return word;
      default: return {word[7:0], 24'h000000};
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request after the last grant, wrapping.
module byte_lane_arbiter_rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  always_comb begin
    logic found;
    int   j;
    found    = 1'b0;
    j        = 0;
    onehot_o = '0;
    idx_o    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(last_i) + k) % NREQ;
      if (!found && req_i[j]) begin
        found       = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = IDW'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/byte_lane_arbiter.sv
// Round-robin sharing of one 8-bit serial lane; words leave MSB byte first, no bubble between words.
module byte_lane_arbiter
  import byte_lane_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enb,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    reqS,
  input  logic [32*NREQ-1:0]   reqData,
  output logic [NREQ-1:0]      ack,
  output logic [7:0]           dataOut,
  output logic                 validOut,
  output logic                 sofOut,
  output logic                 eofOut,
  output logic [1:0]           laneS,
  output logic [IDW-1:0]       grantId
);

  logic [NREQ-1:0][31:0] word_v;
  logic [NREQ-1:0][1:0]  code_v;
  logic [NREQ-1:0]       pick_oh;
  logic [IDW-1:0]        pick_idx;
  logic                  pick_any;
  logic                  arb;

  lane_t                 lane_q, lane_d;
  logic [IDW-1:0]        grant_q, grant_d;
  logic [IDW-1:0]        last_q, last_d;
  logic [NREQ-1:0]       ack_q, ack_d;

  assign word_v = reqData;
  assign code_v = reqS;

  byte_lane_arbiter_rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // The owner's last byte and the next grant share one edge, so lanes never idle between words.
  assign arb = enb && pick_any && (!lane_q.busy || lane_q.cnt == 2'd0);

  always_comb begin
    lane_d  = lane_q;
    grant_d = grant_q;
    last_d  = last_q;
    ack_d   = '0;
    if (arb) begin
      lane_d.busy  = 1'b1;
      lane_d.first = 1'b1;
      lane_d.code  = code_v[pick_idx];
      lane_d.sh    = align_msb(code_v[pick_idx], word_v[pick_idx]);
      lane_d.cnt   = 2'(bytes_of(code_v[pick_idx]) - 3'd1);
      grant_d      = pick_idx;
      last_d       = pick_idx;
      ack_d        = pick_oh;
    end else if (enb && lane_q.busy) begin
      lane_d.first = 1'b0;
      if (lane_q.cnt != 2'd0) begin
        lane_d.sh  = {lane_q.sh[23:0], 8'h00};
        lane_d.cnt = lane_q.cnt - 2'd1;
      end else begin
        lane_d.busy = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q  <= '0;
      grant_q <= '0;
      last_q  <= IDW'(NREQ - 1);
      ack_q   <= '0;
    end else begin
      lane_q  <= lane_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
    end
  end

  assign ack      = ack_q;
  assign dataOut  = lane_q.sh[31:24];
  assign validOut = lane_q.busy & enb;
  assign sofOut   = lane_q.busy & lane_q.first;
  assign eofOut   = lane_q.busy & (lane_q.cnt == 2'd0);
  assign laneS    = lane_q.code;
  assign grantId  = grant_q;

endmodule

// File: tb/tb_byte_lane_arbiter.sv
// Directed bench for byte_lane_arbiter: byte-queue reference model plus literal traces per scenario.
module tb_byte_lane_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                enb = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [2*NREQ-1:0]   reqS = '0;
  logic [32*NREQ-1:0]  reqData = '0;
  logic [NREQ-1:0]     ack;
  logic [7:0]          dataOut;
  logic                validOut, sofOut, eofOut;
  logic [1:0]          laneS;
  logic [IDW-1:0]      grantId;

  byte_lane_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .enb(enb), .req(req), .reqS(reqS), .reqData(reqData),
    .ack(ack), .dataOut(dataOut), .validOut(validOut), .sofOut(sofOut),
    .eofOut(eofOut), .laneS(laneS), .grantId(grantId)
  );

  always #5 clk = ~clk;

  // Reference: the word in flight is simply a queue of its bytes, head = presented byte.
  logic [7:0]      mq[$];
  int              mn = 0, mown = 0, mlast = NREQ - 1, mw = 0;
  logic [1:0]      mcode = 2'b00;
  logic [NREQ-1:0] mack = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete(); mn = 0; mown = 0; mlast = NREQ - 1; mcode = 2'b00; mack = '0;
    end else begin
      mack = '0;
      if (enb) begin
        if (mq.size() > 0) void'(mq.pop_front());
        if (mq.size() == 0 && req != '0) begin
          mw = -1;
          for (int k = 1; k <= NREQ; k++)
            if (mw < 0 && req[(mlast + k) % NREQ]) mw = (mlast + k) % NREQ;
          mcode = reqS[2*mw +: 2];
          mn = (mcode == 2'b01) ? 2 : (mcode == 2'b10) ? 4 : 1;
          for (int b = mn - 1; b >= 0; b--) mq.push_back(reqData[32*mw + 8*b +: 8]);
          mown = mw; mlast = mw; mack[mw] = 1'b1;
        end
      end
    end
  end

  int          total = 0, bad = 0;
  int          ackcnt[NREQ];
  logic [33:0] wq[NREQ][$];
  logic [13:0] cap[$];

  function automatic logic [13:0] mk(input logic [1:0] g, input logic [1:0] s,
                                     input logic so, input logic eo, input logic [7:0] d);
    return {g, s, so, eo, d};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkcap(input string nm, input int idx, input logic [13:0] exp);
    if (idx < cap.size()) chk(nm, 32'(cap[idx]), 32'(exp));
    else begin
      total++; bad++;
      $display("FAIL %s: entry %0d missing, required %h", nm, idx, exp);
    end
  endtask

  task automatic drive();
    logic [33:0] e;
    for (int i = 0; i < NREQ; i++) begin
      if (wq[i].size() > 0) begin
        e = wq[i][0];
        req[i] = 1'b1; reqS[2*i +: 2] = e[33:32]; reqData[32*i +: 32] = e[31:0];
      end else req[i] = 1'b0;
    end
  endtask

  task automatic compare();
    chk("valid", 32'(validOut), 32'((mq.size() > 0) && enb));
    chk("ack", 32'(ack), 32'(mack));
    for (int i = 0; i < NREQ; i++) if (ack[i]) ackcnt[i]++;
    if (mq.size() > 0) begin
      chk("data", 32'(dataOut), 32'(mq[0]));
      chk("sof", 32'(sofOut), 32'(mq.size() == mn));
      chk("eof", 32'(eofOut), 32'(mq.size() == 1));
      chk("laneS", 32'(laneS), 32'(mcode));
      chk("grant", 32'(grantId), 32'(mown));
    end else begin
      chk("sof_idle", 32'(sofOut), 32'd0);
      chk("eof_idle", 32'(eofOut), 32'd0);
    end
    if (validOut) cap.push_back(mk(grantId, laneS, sofOut, eofOut, dataOut));
  endtask

  // Inputs change 2 units after posedge, outputs are checked at negedge.
  task automatic tick();
    @(posedge clk); #2;
    for (int i = 0; i < NREQ; i++) if (mack[i] && wq[i].size() > 0) void'(wq[i].pop_front());
    drive();
    @(negedge clk);
    if (rst) compare();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_data"},  32'(dataOut),  32'd0);
    chk({nm, "_valid"}, 32'(validOut), 32'd0);
    chk({nm, "_sof"},   32'(sofOut),   32'd0);
    chk({nm, "_eof"},   32'(eofOut),   32'd0);
    chk({nm, "_laneS"}, 32'(laneS),    32'd0);
    chk({nm, "_grant"}, 32'(grantId),  32'd0);
    chk({nm, "_ack"},   32'(ack),      32'd0);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cap.delete();
    for (int i = 0; i < NREQ; i++) ackcnt[i] = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; enb = 1'b1;
    for (int i = 0; i < NREQ; i++) wq[i].delete();
    drive();
    #1 chk_zero("rst");
    release_reset();
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) ackcnt[i] = 0;
    #1 rst = 1'b0;

    // single 32-bit word
    apply_reset();
    wq[0].push_back({2'b10, 32'hA1B2C3D4}); drive();
    repeat (6) tick();
    chk("t1_len", 32'(cap.size()), 32'd4);
    chkcap("t1_b0", 0, mk(2'd0, 2'b10, 1'b1, 1'b0, 8'hA1));
    chkcap("t1_b1", 1, mk(2'd0, 2'b10, 1'b0, 1'b0, 8'hB2));
    chkcap("t1_b2", 2, mk(2'd0, 2'b10, 1'b0, 1'b0, 8'hC3));
    chkcap("t1_b3", 3, mk(2'd0, 2'b10, 1'b0, 1'b1, 8'hD4));
    chk("t1_ack0", 32'(ackcnt[0]), 32'd1);

    // round robin, all four held, requester 0 offers twice
    apply_reset();
    wq[0].push_back({2'b00, 32'h10}); wq[0].push_back({2'b00, 32'h10});
    wq[1].push_back({2'b00, 32'h11}); wq[2].push_back({2'b00, 32'h12});
    wq[3].push_back({2'b00, 32'h13}); drive();
    repeat (5) tick();
    chk("t2_contig", 32'(cap.size()), 32'd5);
    chkcap("t2_g0", 0, mk(2'd0, 2'b00, 1'b1, 1'b1, 8'h10));
    chkcap("t2_g1", 1, mk(2'd1, 2'b00, 1'b1, 1'b1, 8'h11));
    chkcap("t2_g2", 2, mk(2'd2, 2'b00, 1'b1, 1'b1, 8'h12));
    chkcap("t2_g3", 3, mk(2'd3, 2'b00, 1'b1, 1'b1, 8'h13));
    chkcap("t2_g0b", 4, mk(2'd0, 2'b00, 1'b1, 1'b1, 8'h10));
    repeat (3) tick();
    chk("t2_ack0", 32'(ackcnt[0]), 32'd2);
    chk("t2_ack3", 32'(ackcnt[3]), 32'd1);

    // mixed widths back-to-back
    apply_reset();
    wq[1].push_back({2'b01, 32'h0000BEEF}); wq[2].push_back({2'b00, 32'h5A}); drive();
    repeat (3) tick();
    chk("t3_contig", 32'(cap.size()), 32'd3);
    chkcap("t3_be", 0, mk(2'd1, 2'b01, 1'b1, 1'b0, 8'hBE));
    chkcap("t3_ef", 1, mk(2'd1, 2'b01, 1'b0, 1'b1, 8'hEF));
    chkcap("t3_5a", 2, mk(2'd2, 2'b00, 1'b1, 1'b1, 8'h5A));
    repeat (2) tick();

    // stall after B2
    apply_reset();
    wq[0].push_back({2'b10, 32'hA1B2C3D4}); drive();
    repeat (2) tick();
    enb = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("t4_stall_valid", 32'(validOut), 32'd0);
      chk("t4_stall_hold", 32'(dataOut), 32'hB2);
    end
    enb = 1'b1;
    #1 chk("t4_resume_valid", 32'(validOut), 32'd1);
    chk("t4_resume_data", 32'(dataOut), 32'hB2);
    repeat (4) tick();
    chk("t4_len", 32'(cap.size()), 32'd4);
    chkcap("t4_b1", 1, mk(2'd0, 2'b10, 1'b0, 1'b0, 8'hB2));
    chkcap("t4_b2", 2, mk(2'd0, 2'b10, 1'b0, 1'b0, 8'hC3));
    chkcap("t4_b3", 3, mk(2'd0, 2'b10, 1'b0, 1'b1, 8'hD4));
    chk("t4_ack0", 32'(ackcnt[0]), 32'd1);

    // async reset while C3 is presented
    apply_reset();
    wq[0].push_back({2'b10, 32'hA1B2C3D4}); drive();
    repeat (3) tick();
    chkcap("t5_c3", 2, mk(2'd0, 2'b10, 1'b0, 1'b0, 8'hC3));
    #2 rst = 1'b0;
    #1 chk_zero("t5_async");
    for (int i = 0; i < NREQ; i++) wq[i].delete();
    drive();
    release_reset();
    wq[1].push_back({2'b00, 32'h77}); wq[0].push_back({2'b10, 32'hA1B2C3D4}); drive();
    repeat (6) tick();
    chkcap("t5_restart", 0, mk(2'd0, 2'b10, 1'b1, 1'b0, 8'hA1));
    chkcap("t5_end", 3, mk(2'd0, 2'b10, 1'b0, 1'b1, 8'hD4));
    chkcap("t5_next", 4, mk(2'd1, 2'b00, 1'b1, 1'b1, 8'h77));
    chk("t5_ack0", 32'(ackcnt[0]), 32'd1);
    chk("t5_ack1", 32'(ackcnt[1]), 32'd1);

    // width code 11 acts as a single byte
    apply_reset();
    wq[0].push_back({2'b11, 32'h000000FF}); drive();
    repeat (3) tick();
    chk("t6_len", 32'(cap.size()), 32'd1);
    chkcap("t6_ff", 0, mk(2'd0, 2'b11, 1'b1, 1'b1, 8'hFF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/byte_lane_arbiter.md
Name: byte_lane_arbiter

Overview:
- Shares one 8-bit serial byte lane between NREQ requesters.
- Each requester offers an 8-, 16- or 32-bit word, tagged with the same width code the lane serializers use: 00/11 = 8, 01 = 16, 10 = 32.
- Round-robin arbitration picks a winner, latches its word, and emits it MSB byte first, one byte per consumed clk.
- Sits upstream of the byte lane and replaces per-source width muxing with one sequenced, shared channel.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of grant index; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  base-frequency clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- enb  in  1  lane enable; the lane consumes the presented byte at a posedge where enb=1.
- req  in  NREQ  per-requester word-available flag.
- reqS  in  2*NREQ  width code of requester i in bits [2i+1:2i].
- reqData  in  32*NREQ  word of requester i in bits [32i+31:32i], right-aligned.
- ack  out  NREQ  one-cycle pulse: word of requester i latched.
- dataOut  out  8  presented byte.
- validOut  out  1  dataOut is valid; equals busy & enb (combinational).
- sofOut  out  1  presented byte is the first byte of its word.
- eofOut  out  1  presented byte is the last byte of its word.
- laneS  out  2  width code of the word in flight.
- grantId  out  IDW  index of the current owner.

Behaviour:
- Reset (rst=0, async):
  - busy=0, shift register=0, cnt=0.
  - dataOut=0, sofOut=0, eofOut=0, laneS=00, grantId=0, ack=0.
  - lastGrant=NREQ-1, so requester 0 has first priority.
- Registers:
  - busy.
  - sh[31:0]; dataOut=sh[31:24].
  - cnt[1:0], bytes remaining after the current one.
  - first flag.
  - laneS, grantId, lastGrant.
- Arbitration event (posedge with enb=1 and req!=0):
  - Fires when busy=0, or when busy=1 and cnt=0 (last byte consumed this edge).
  - Winner: first set req bit scanning lastGrant+1, lastGrant+2, ... modulo NREQ.
  - Load sh: width 8 -> {d[7:0],24'h0}; 16 -> {d[15:0],16'h0}; 32 -> d.
  - Load cnt = bytes-1 (0/1/3); set busy=1, first=1, laneS=code, grantId=winner, lastGrant=winner.
  - ack[winner]=1 for exactly the following cycle.
  - Back-to-back words therefore have no idle bubble.
- Consume (posedge, enb=1, busy=1, cnt!=0): sh <<= 8, cnt--, first=0.
- Last byte consumed (cnt=0) with no arbitration event: busy=0, sofOut=0, eofOut=0.
- sofOut = busy & first; eofOut = busy & (cnt==0).
- enb=0: all state frozen (including arbitration), validOut=0, dataOut holds; the same byte is re-presented when enb returns.
- Requesters:
  - A requester keeps req, reqS and reqData stable until its ack.
  - Holding req high after ack offers a new word.
  - Data is sampled only at the arbitration edge.
- Width code 11 is treated as 8-bit; laneS reports 11 unchanged.
- Latency: first byte valid in the cycle after the arbitration edge (if enb=1); an N-byte word occupies N consuming edges.
- Reset mid-word discards the word. No ack is reissued, and the requester must re-offer.
- req bits of the current owner are ignored until its arbitration point.

Decomposition:
- Shared package constants:
  - W8=2'b00, W16=2'b01, W32=2'b10, W8ALT=2'b11.
  - Function bytes_of(code) -> 1/2/4.
  - Function align_msb(code, word).
- Sub-module rr_picker:
  - Combinational round-robin priority pick over NREQ.
  - Outputs one-hot plus index and any flag.
  - Inputs req and lastGrant.
- Top holds the FSM (IDLE/busy via busy flag), shifter and counters.

Test Plan:
- Reset then single 32-bit word: req0=1, reqS0=10, data 0xA1B2C3D4, enb=1.
  - ack0 pulses once.
  - dataOut A1,B2,C3,D4 on consecutive cycles; sofOut on A1, eofOut on D4, laneS=10.
- Round-robin: req0..3 all held, each 8-bit with data 0x10,0x11,0x12,0x13.
  - Grants 0,1,2,3,0 with no idle cycle.
  - validOut continuous; each ack one cycle.
- Mixed widths back-to-back: req1 16-bit 0xBEEF, then req2 8-bit 0x5A.
  - Bytes BE,EF,5A contiguous; eofOut on EF and on 5A.
  - sofOut on BE and 5A; laneS changes 01 -> 00 with the 5A byte.
- Stall: enb=0 for 3 cycles after byte B2 of 0xA1B2C3D4.
  - validOut=0 during the stall, dataOut holds B2.
  - Resumes B2,C3,D4 with no loss or duplication after the stall.
- Async reset mid-word: rst pulled low between clk edges during C3.
  - All outputs 0 immediately.
  - After release, req0 wins first again; the word restarts from A1 after a new ack.
- Width code 11 with data 0x000000FF: single byte FF, with sofOut=eofOut=1 on it and laneS=11.
